fsm_escribir_rtc: RTL

- Counterpart of the RTC-to-RAM read sequencers: copies REG_COUNT bytes from the shared register RAM into consecutive RTC registers.
- Drives the RTC multiplexed address/data bus directly, using a two-phase write cycle: address phase, then data phase.
- Started by the top-level control FSM when the user commits a new time or date.
- Owns the RAM read port and the RTC bus for the whole burst.

---
 rtl/fsm_escribir_rtc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fsm_escribir_rtc.sv
// Burst writer: copies REG_COUNT bytes from the register RAM into consecutive RTC
// registers using a two-phase (address, then data) cycle on the multiplexed AD bus.
module fsm_escribir_rtc #(
    parameter int          REG_COUNT = 3,
    parameter logic [7:0]  RTC_BASE  = 8'h21,
    parameter int          RAM_BASE  = 0,
    parameter int          RAM_AW    = 6,
    parameter int          T_SU      = 2,
    parameter int          T_PW      = 6,
    parameter int          T_H       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              do_it_escribir,
    output logic [RAM_AW-1:0] dir_ram,
    output logic              r_ram_enable,
    input  logic [7:0]        ram_data,
    output logic              a_d,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [7:0]        ad_out,
    output logic              ad_oe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE, FETCH0, FETCH1, A_SU, A_PW, A_H, D_SU, D_PW, D_H, REC, FIN
    } state_t;

    localparam logic [3:0] SU_LAST = 4'(T_SU - 1);
    localparam logic [3:0] PW_LAST = 4'(T_PW - 1);
    localparam logic [3:0] H_LAST  = 4'(T_H - 1);
    localparam logic [2:0] K_LAST  = 3'(REG_COUNT - 1);

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;

    logic [RAM_AW-1:0] dir_q, dir_d;
    logic              r_en_q, r_en_d;
    logic              a_d_q, a_d_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [7:0]        ad_q, ad_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q + 4'd1;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (do_it_escribir) begin
                    state_d = FETCH0;
                    k_d     = 3'd0;
                end
            end
            FETCH0: state_d = FETCH1;
            FETCH1: begin
                state_d = A_SU;
                data_d  = ram_data;
            end
            A_SU: if (cnt_q == SU_LAST) state_d = A_PW;
            A_PW: if (cnt_q == PW_LAST) state_d = A_H;
            A_H:  if (cnt_q == H_LAST)  state_d = D_SU;
            D_SU: if (cnt_q == SU_LAST) state_d = D_PW;
            D_PW: if (cnt_q == PW_LAST) state_d = D_H;
            D_H:  if (cnt_q == H_LAST)  state_d = REC;
            REC: begin
                if (k_q == K_LAST) begin
                    state_d = FIN;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = FETCH0;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q || state_q == IDLE) cnt_d = 4'd0;
    end

    // NOTE: outputs are decoded from the *next* state and registered, so the bus
    // pins (cs/wr especially) come straight from flops and line up with state_q.
    always_comb begin
        dir_d  = '0;
        r_en_d = 1'b0;
        a_d_d  = 1'b1;
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        ad_d   = 8'h00;
        oe_d   = 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        unique case (state_d)
            FETCH0: begin
                r_en_d = 1'b1;
                dir_d  = RAM_AW'(RAM_BASE) + RAM_AW'(k_d);
            end
            A_SU, A_PW, A_H: begin
                cs_d  = 1'b0;
                a_d_d = 1'b0;
                oe_d  = 1'b1;
                ad_d  = RTC_BASE + 8'(k_d);
                wr_d  = (state_d != A_PW);
            end
            D_SU, D_PW, D_H: begin
                cs_d  = 1'b0;
                oe_d  = 1'b1;
                ad_d  = data_d;
                wr_d  = (state_d != D_PW);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            cnt_q   <= 4'd0;
            data_q  <= 8'h00;
            dir_q   <= '0;
            r_en_q  <= 1'b0;
            a_d_q   <= 1'b1;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            ad_q    <= 8'h00;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            r_en_q  <= r_en_d;
            a_d_q   <= a_d_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            ad_q    <= ad_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dir_ram      = dir_q;
    assign r_ram_enable = r_en_q;
    assign a_d          = a_d_q;
    assign cs           = cs_q;
    assign rd           = 1'b1;
    assign wr           = wr_q;
    assign ad_out       = ad_q;
    assign ad_oe        = oe_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
